// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: FSM states, requester IDs and burst
// geometry derived from the bus/block width parameters.
package l2_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_CMD  = 3'd3,
    WR_DATA = 3'd4,
    WR_WAIT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ID_INS = 2'd0,
    ID_DRD = 2'd1,
    ID_DWR = 2'd2
  } req_id_e;

  // A block of 2^b bits on a 2^w-bit bus takes 2^(b-w) beats.
  function automatic int burst_len(input int w, input int b);
    return 1 << (b - w);
  endfunction

  // log2(BURST), floored at 1 so a single-beat config still has a counter bit.
  function automatic int beat_cnt_w(input int w, input int b);
    return (b > w) ? (b - w) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. The pointer names the requester that wins a
// tie and flips to the other side whenever a grant is taken (upd_i).
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = req_i[0] & (~ptr_q | ~req_i[1]);
    gnt_o[1] = req_i[1] & ( ptr_q | ~req_i[0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                ptr_q <= 1'b0;
    else if (upd_i && |gnt_o)   ptr_q <= gnt_o[0];
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates I-cache reads, D-cache reads and D-cache write-backs onto one
// memory port, one burst transaction outstanding at a time.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int W  = 7,
  parameter int B  = 9,
  parameter int AW = 30
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                INS_ADDR_VALID,
  output logic                INS_ADDR_READY,
  input  logic [AW-1:0]       INS_ADDR,
  output logic                INS_DATA_VALID,
  input  logic                INS_DATA_READY,
  output logic [(1<<W)-1:0]   INS_DATA,
  input  logic                DRD_ADDR_VALID,
  output logic                DRD_ADDR_READY,
  input  logic [AW-1:0]       DRD_ADDR,
  output logic                DRD_DATA_VALID,
  input  logic                DRD_DATA_READY,
  output logic [(1<<W)-1:0]   DRD_DATA,
  input  logic                DWR_VALID,
  output logic                DWR_READY,
  input  logic [AW-1:0]       DWR_ADDR,
  input  logic [(1<<W)-1:0]   DWR_DATA,
  input  logic                DWR_CONTROL,
  output logic                DWR_COMPLETE,
  output logic                MEM_CMD_VALID,
  input  logic                MEM_CMD_READY,
  output logic                MEM_CMD_WRITE,
  output logic [AW-1:0]       MEM_CMD_ADDR,
  output logic                MEM_CMD_CONTROL,
  output logic                MEM_WDATA_VALID,
  input  logic                MEM_WDATA_READY,
  output logic [(1<<W)-1:0]   MEM_WDATA,
  input  logic                MEM_RDATA_VALID,
  output logic                MEM_RDATA_READY,
  input  logic [(1<<W)-1:0]   MEM_RDATA,
  input  logic                MEM_WR_DONE
);

  localparam int L2W   = 1 << W;
  localparam int BURST = burst_len(W, B);
  localparam int CW    = beat_cnt_w(W, B);

  state_e         state_q;
  req_id_e        id_q;
  logic [AW-1:0]  addr_q;
  logic           ctrl_q;
  logic [L2W-1:0] wdata_q;
  logic [CW-1:0]  beat_q;
  logic           complete_q;
  logic           live_q;

  logic [1:0] rd_gnt;
  logic       idle_grant, wr_grant, rd_grant, rd_data, beat_acc, last_beat;

  // live_q holds off grants until the first clock edge after reset release.
  assign idle_grant = (state_q == IDLE) & live_q;
  assign wr_grant   = idle_grant & DWR_VALID;
  assign rd_grant   = idle_grant & ~DWR_VALID & (INS_ADDR_VALID | DRD_ADDR_VALID);

  rr_arb2 u_rr (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .req_i  ({DRD_ADDR_VALID, INS_ADDR_VALID}),
    .upd_i  (rd_grant),
    .gnt_o  (rd_gnt)
  );

  assign INS_ADDR_READY  = rd_grant & rd_gnt[0];
  assign DRD_ADDR_READY  = rd_grant & rd_gnt[1];

  assign MEM_CMD_VALID   = (state_q == RD_CMD) | (state_q == WR_CMD);
  assign MEM_CMD_WRITE   = (state_q == WR_CMD);
  assign MEM_CMD_ADDR    = addr_q;
  assign MEM_CMD_CONTROL = ctrl_q;

  assign rd_data         = (state_q == RD_DATA);
  assign MEM_RDATA_READY = rd_data & ((id_q == ID_DRD) ? DRD_DATA_READY : INS_DATA_READY);
  assign INS_DATA_VALID  = rd_data & (id_q == ID_INS) & MEM_RDATA_VALID;
  assign DRD_DATA_VALID  = rd_data & (id_q == ID_DRD) & MEM_RDATA_VALID;
  assign INS_DATA        = MEM_RDATA;
  assign DRD_DATA        = MEM_RDATA;

  // Beat 0 replays the word captured at grant; later beats stream straight through.
  assign MEM_WDATA_VALID = (state_q == WR_DATA);
  assign MEM_WDATA       = (beat_q == '0) ? wdata_q : DWR_DATA;
  assign DWR_READY       = wr_grant | (MEM_WDATA_VALID & (beat_q != '0) & MEM_WDATA_READY);
  assign DWR_COMPLETE    = complete_q;

  assign beat_acc  = (rd_data & MEM_RDATA_VALID & MEM_RDATA_READY) |
                     (MEM_WDATA_VALID & MEM_WDATA_READY);
  assign last_beat = (beat_q == CW'(BURST - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      id_q       <= ID_INS;
      addr_q     <= '0;
      ctrl_q     <= 1'b0;
      wdata_q    <= '0;
      beat_q     <= '0;
      complete_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      complete_q <= 1'b0;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (wr_grant) begin
            id_q    <= ID_DWR;
            addr_q  <= DWR_ADDR;
            ctrl_q  <= DWR_CONTROL;
            wdata_q <= DWR_DATA;
            state_q <= WR_CMD;
          end else if (rd_grant) begin
            id_q    <= rd_gnt[0] ? ID_INS : ID_DRD;
            addr_q  <= rd_gnt[0] ? INS_ADDR : DRD_ADDR;
            ctrl_q  <= 1'b0;
            state_q <= RD_CMD;
          end
        end
        RD_CMD:  if (MEM_CMD_READY) state_q <= RD_DATA;
        WR_CMD:  if (MEM_CMD_READY) state_q <= WR_DATA;
        RD_DATA: if (beat_acc) begin
          beat_q <= beat_q + CW'(1);
          if (last_beat) state_q <= IDLE;
        end
        WR_DATA: if (beat_acc) begin
          beat_q <= beat_q + CW'(1);
          if (last_beat) state_q <= WR_WAIT;
        end
        WR_WAIT: if (MEM_WR_DONE) begin
          complete_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: a small memory responder plus one task
// per scenario, each comparing against hand-derived expectations.
module tb_l2_port_arbiter;

  localparam int W = 7, B = 9, AW = 30, L2W = 128;

  logic           CLK = 1'b0, RSTN;
  logic           INS_ADDR_VALID, INS_ADDR_READY, INS_DATA_VALID, INS_DATA_READY;
  logic [AW-1:0]  INS_ADDR;
  logic [L2W-1:0] INS_DATA;
  logic           DRD_ADDR_VALID, DRD_ADDR_READY, DRD_DATA_VALID, DRD_DATA_READY;
  logic [AW-1:0]  DRD_ADDR;
  logic [L2W-1:0] DRD_DATA;
  logic           DWR_VALID, DWR_READY, DWR_CONTROL, DWR_COMPLETE;
  logic [AW-1:0]  DWR_ADDR;
  logic [L2W-1:0] DWR_DATA;
  logic           MEM_CMD_VALID, MEM_CMD_READY, MEM_CMD_WRITE, MEM_CMD_CONTROL;
  logic [AW-1:0]  MEM_CMD_ADDR;
  logic           MEM_WDATA_VALID, MEM_WDATA_READY, MEM_RDATA_VALID, MEM_RDATA_READY, MEM_WR_DONE;
  logic [L2W-1:0] MEM_WDATA, MEM_RDATA;

  logic cmd_rdy_en, wrdy_en, spur, m_rvalid;
  logic [L2W-1:0] m_rdata;
  logic [AW-1:0]  m_raddr;
  int m_rbeat, m_wbeats, m_wdly;
  int cyc = 0, checks = 0, failures = 0;
  int drd_vld_cnt = 0, cmpl_cnt = 0, done_at = -1, cmpl_at = -1;
  int gnt_log[$];
  logic [AW-1:0]  cmd_addr[$];
  logic           cmd_wr[$], cmd_ctl[$];
  logic [L2W-1:0] ins_log[$], drd_log[$], wlog[$];
  logic [8:0] ctl_outs;

  assign MEM_CMD_READY   = cmd_rdy_en;
  assign MEM_WDATA_READY = wrdy_en;
  assign MEM_RDATA_VALID = m_rvalid | spur;
  assign MEM_RDATA       = m_rdata;
  assign ctl_outs = {INS_ADDR_READY, DRD_ADDR_READY, DWR_READY, MEM_CMD_VALID, MEM_WDATA_VALID,
                     MEM_RDATA_READY, INS_DATA_VALID, DRD_DATA_VALID, DWR_COMPLETE};

  l2_port_arbiter #(.W(W), .B(B), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .INS_ADDR_VALID(INS_ADDR_VALID), .INS_ADDR_READY(INS_ADDR_READY), .INS_ADDR(INS_ADDR),
    .INS_DATA_VALID(INS_DATA_VALID), .INS_DATA_READY(INS_DATA_READY), .INS_DATA(INS_DATA),
    .DRD_ADDR_VALID(DRD_ADDR_VALID), .DRD_ADDR_READY(DRD_ADDR_READY), .DRD_ADDR(DRD_ADDR),
    .DRD_DATA_VALID(DRD_DATA_VALID), .DRD_DATA_READY(DRD_DATA_READY), .DRD_DATA(DRD_DATA),
    .DWR_VALID(DWR_VALID), .DWR_READY(DWR_READY), .DWR_ADDR(DWR_ADDR), .DWR_DATA(DWR_DATA),
    .DWR_CONTROL(DWR_CONTROL), .DWR_COMPLETE(DWR_COMPLETE),
    .MEM_CMD_VALID(MEM_CMD_VALID), .MEM_CMD_READY(MEM_CMD_READY), .MEM_CMD_WRITE(MEM_CMD_WRITE),
    .MEM_CMD_ADDR(MEM_CMD_ADDR), .MEM_CMD_CONTROL(MEM_CMD_CONTROL),
    .MEM_WDATA_VALID(MEM_WDATA_VALID), .MEM_WDATA_READY(MEM_WDATA_READY), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA_VALID(MEM_RDATA_VALID), .MEM_RDATA_READY(MEM_RDATA_READY), .MEM_RDATA(MEM_RDATA),
    .MEM_WR_DONE(MEM_WR_DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [L2W-1:0] pat(input logic [AW-1:0] a, input int b);
    return {32'h1000 + 32'(b), 32'hCAFE_0000 | 32'(b), 2'b00, a, 32'(a) ^ 32'hDEAD_BEEF};
  endfunction

  function automatic logic [L2W-1:0] wdat(input int k);
    return {4{32'h5A00_0000 + 32'(k)}};
  endfunction

  // Memory responder and traffic monitor.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_rvalid <= 1'b0; m_rdata <= '0; m_raddr <= '0; m_rbeat <= 0;
      m_wbeats <= 0; m_wdly <= 0; MEM_WR_DONE <= 1'b0;
    end else begin
      MEM_WR_DONE <= 1'b0;
      if (INS_ADDR_VALID && INS_ADDR_READY) gnt_log.push_back(0);
      if (DRD_ADDR_VALID && DRD_ADDR_READY) gnt_log.push_back(1);
      if (DWR_VALID && DWR_READY && !MEM_WDATA_VALID) gnt_log.push_back(2);
      if (INS_DATA_VALID && INS_DATA_READY) ins_log.push_back(INS_DATA);
      if (DRD_DATA_VALID && DRD_DATA_READY) drd_log.push_back(DRD_DATA);
      if (DRD_DATA_VALID) drd_vld_cnt <= drd_vld_cnt + 1;
      if (MEM_WR_DONE) done_at <= cyc;
      if (DWR_COMPLETE) begin cmpl_cnt <= cmpl_cnt + 1; cmpl_at <= cyc; end
      if (m_rvalid && MEM_RDATA_READY) begin
        if (m_rbeat == 3) m_rvalid <= 1'b0;
        else begin m_rbeat <= m_rbeat + 1; m_rdata <= pat(m_raddr, m_rbeat + 1); end
      end
      if (MEM_WDATA_VALID && MEM_WDATA_READY) begin
        wlog.push_back(MEM_WDATA);
        if (m_wbeats == 3) m_wdly <= 3;
        m_wbeats <= m_wbeats + 1;
      end
      if (m_wdly != 0) begin
        m_wdly <= m_wdly - 1;
        if (m_wdly == 1) MEM_WR_DONE <= 1'b1;
      end
      if (MEM_CMD_VALID && MEM_CMD_READY) begin
        cmd_addr.push_back(MEM_CMD_ADDR); cmd_wr.push_back(MEM_CMD_WRITE);
        cmd_ctl.push_back(MEM_CMD_CONTROL);
        if (!MEM_CMD_WRITE) begin
          m_rvalid <= 1'b1; m_rbeat <= 0; m_raddr <= MEM_CMD_ADDR; m_rdata <= pat(MEM_CMD_ADDR, 0);
        end else m_wbeats <= 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    INS_ADDR_VALID = 0; DRD_ADDR_VALID = 0; DWR_VALID = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; INS_ADDR_VALID = 1; DRD_ADDR_VALID = 0; DWR_VALID = 1;
    #3;
    checks++; if (ctl_outs !== 9'b0) begin failures++; $display("FAIL reset_outs got=%b want=0", ctl_outs); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
    #1;
    checks++; if (ctl_outs !== 9'b0) begin failures++; $display("FAIL release_no_grant got=%b want=0", ctl_outs); end
    @(posedge CLK); #1;
    INS_ADDR_VALID = 0; DWR_VALID = 0;
    repeat (6) @(posedge CLK);
    checks++; if (gnt_log.size() != 0 || cmd_addr.size() != 0) begin
      failures++; $display("FAIL dropped_req grants=%0d cmds=%0d want=0", gnt_log.size(), cmd_addr.size());
    end
    @(negedge CLK) spur = 1'b1;
    #1;
    checks++; if ({MEM_RDATA_READY, INS_DATA_VALID, DRD_DATA_VALID} !== 3'b0) begin
      failures++; $display("FAIL idle_rdata got=%b want=000", {MEM_RDATA_READY, INS_DATA_VALID, DRD_DATA_VALID});
    end
    @(negedge CLK) spur = 1'b0;
  endtask

  task automatic test_ins_read();
    int c0 = cmd_addr.size(), i0 = ins_log.size(), d0 = drd_vld_cnt;
    bit granted = 0;
    @(posedge CLK); #1 INS_ADDR = 30'h54; INS_ADDR_VALID = 1;
    for (int n = 0; n < 20 && !granted; n++) begin @(negedge CLK); if (INS_ADDR_READY) granted = 1; end
    @(posedge CLK); #1 INS_ADDR_VALID = 0;
    for (int n = 0; n < 60 && ins_log.size() < i0 + 4; n++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    checks++; if (!granted || cmd_addr.size() != c0 + 1) begin
      failures++; $display("FAIL ins_cmd_count got=%0d want=1", cmd_addr.size() - c0);
    end else begin
      checks++; if (cmd_addr[c0] !== 30'h54 || cmd_wr[c0] !== 1'b0) begin
        failures++; $display("FAIL ins_cmd addr=%h wr=%b want 0000054/0", cmd_addr[c0], cmd_wr[c0]);
      end
    end
    checks++; if (ins_log.size() != i0 + 4) begin
      failures++; $display("FAIL ins_beats got=%0d want=4", ins_log.size() - i0);
    end else for (int k = 0; k < 4; k++) begin
      checks++; if (ins_log[i0 + k] !== pat(30'h54, k)) begin
        failures++; $display("FAIL ins_beat%0d got=%h want=%h", k, ins_log[i0 + k], pat(30'h54, k));
      end
    end
    checks++; if (drd_vld_cnt != d0) begin failures++; $display("FAIL drd_quiet got=%0d want=0", drd_vld_cnt - d0); end
  endtask

  task automatic test_round_robin();
    int g0, c0, b0;
    do_reset();
    g0 = gnt_log.size(); c0 = cmd_addr.size(); b0 = ins_log.size() + drd_log.size();
    @(posedge CLK); #1 INS_ADDR = 30'h100; DRD_ADDR = 30'h200; INS_ADDR_VALID = 1; DRD_ADDR_VALID = 1;
    for (int n = 0; n < 400 && gnt_log.size() < g0 + 6; n++) @(negedge CLK);
    INS_ADDR_VALID = 0; DRD_ADDR_VALID = 0;
    for (int n = 0; n < 300 && ins_log.size() + drd_log.size() < b0 + 24; n++) @(negedge CLK);
    checks++; if (gnt_log.size() != g0 + 6 || cmd_addr.size() != c0 + 6) begin
      failures++; $display("FAIL rr_count grants=%0d cmds=%0d want=6", gnt_log.size() - g0, cmd_addr.size() - c0);
    end else for (int i = 0; i < 6; i++) begin
      checks++; if (gnt_log[g0 + i] != i % 2) begin
        failures++; $display("FAIL rr_grant%0d got=%0d want=%0d", i, gnt_log[g0 + i], i % 2);
      end
      checks++; if (cmd_addr[c0 + i] !== ((i % 2) ? 30'h200 : 30'h100)) begin
        failures++; $display("FAIL rr_addr%0d got=%h", i, cmd_addr[c0 + i]);
      end
    end
  endtask

  task automatic test_write_priority();
    int g0, c0, w0, i0, d0, k0, k = 0;
    bit dr, ir, drr;
    do_reset();
    g0 = gnt_log.size(); c0 = cmd_addr.size(); w0 = wlog.size();
    i0 = ins_log.size(); d0 = drd_log.size(); k0 = cmpl_cnt;
    @(posedge CLK); #1;
    DWR_ADDR = 30'h300; DWR_DATA = wdat(0); DWR_CONTROL = 1; DWR_VALID = 1;
    INS_ADDR = 30'h111; DRD_ADDR = 30'h222; INS_ADDR_VALID = 1; DRD_ADDR_VALID = 1;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (ins_log.size() >= i0 + 4 && drd_log.size() >= d0 + 4 && cmpl_cnt > k0) break;
      dr = DWR_READY; ir = INS_ADDR_READY; drr = DRD_ADDR_READY;
      @(posedge CLK); #1;
      if (dr) begin k++; DWR_VALID = 0; if (k < 4) DWR_DATA = wdat(k); end
      if (ir) INS_ADDR_VALID = 0;
      if (drr) DRD_ADDR_VALID = 0;
    end
    INS_ADDR_VALID = 0; DRD_ADDR_VALID = 0; DWR_CONTROL = 0;
    checks++; if (gnt_log.size() != g0 + 3) begin
      failures++; $display("FAIL wr_grants got=%0d want=3", gnt_log.size() - g0);
    end else begin
      checks++; if (gnt_log[g0] != 2 || gnt_log[g0 + 1] != 0 || gnt_log[g0 + 2] != 1) begin
        failures++; $display("FAIL wr_order got=%0d,%0d,%0d want=2,0,1", gnt_log[g0], gnt_log[g0 + 1], gnt_log[g0 + 2]);
      end
      checks++; if (cmd_wr[c0] !== 1'b1 || cmd_addr[c0] !== 30'h300 || cmd_ctl[c0] !== 1'b1) begin
        failures++; $display("FAIL wr_cmd wr=%b addr=%h ctl=%b want 1/0000300/1", cmd_wr[c0], cmd_addr[c0], cmd_ctl[c0]);
      end
    end
    checks++; if (wlog.size() != w0 + 4) begin
      failures++; $display("FAIL wr_beats got=%0d want=4", wlog.size() - w0);
    end else for (int j = 0; j < 4; j++) begin
      checks++; if (wlog[w0 + j] !== wdat(j)) begin
        failures++; $display("FAIL wr_beat%0d got=%h want=%h", j, wlog[w0 + j], wdat(j));
      end
    end
    checks++; if (cmpl_cnt != k0 + 1 || cmpl_at != done_at + 1) begin
      failures++; $display("FAIL wr_complete pulses=%0d at=%0d done=%0d want 1 at done+1", cmpl_cnt - k0, cmpl_at, done_at);
    end
  endtask

  task automatic test_rdata_stall();
    int i0 = ins_log.size(), nacc = 0, stall = 0;
    bit stalled = 0, ir, acc;
    @(posedge CLK); #1 INS_ADDR = 30'h400; INS_ADDR_VALID = 1;
    for (int n = 0; n < 100 && ins_log.size() < i0 + 4; n++) begin
      @(negedge CLK);
      ir = INS_ADDR_READY; acc = INS_DATA_VALID & INS_DATA_READY;
      if (stall > 0) begin
        checks++; if (MEM_RDATA_READY !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b want=0", MEM_RDATA_READY); end
      end
      @(posedge CLK); #1;
      if (ir) INS_ADDR_VALID = 0;
      if (acc) nacc++;
      if (stall > 0) begin stall--; if (stall == 0) INS_DATA_READY = 1; end
      else if (acc && nacc == 2 && !stalled) begin INS_DATA_READY = 0; stall = 2; stalled = 1; end
    end
    repeat (5) @(negedge CLK);
    checks++; if (!stalled || ins_log.size() != i0 + 4) begin
      failures++; $display("FAIL stall_beats got=%0d want=4", ins_log.size() - i0);
    end else for (int k = 0; k < 4; k++) begin
      checks++; if (ins_log[i0 + k] !== pat(30'h400, k)) begin
        failures++; $display("FAIL stall_beat%0d got=%h want=%h", k, ins_log[i0 + k], pat(30'h400, k));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int w0 = wlog.size(), c0 = cmd_addr.size(), d0 = drd_log.size(), k0 = cmpl_cnt, k = 0;
    bit dr, hit = 0, granted = 0;
    @(posedge CLK); #1 DWR_ADDR = 30'h500; DWR_DATA = wdat(10); DWR_VALID = 1;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(negedge CLK);
      if (wlog.size() >= w0 + 1 && MEM_WDATA_VALID) hit = 1;
      else begin
        dr = DWR_READY;
        @(posedge CLK); #1;
        if (dr) begin k++; DWR_VALID = 0; DWR_DATA = wdat(10 + k); end
      end
    end
    RSTN = 1'b0;
    #1;
    checks++; if (!hit || ctl_outs !== 9'b0) begin failures++; $display("FAIL midwrite_reset hit=%0b got=%b want=0", hit, ctl_outs); end
    DWR_VALID = 0;
    @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
    @(posedge CLK); #1 DRD_ADDR = 30'h600; DRD_ADDR_VALID = 1;
    for (int n = 0; n < 20 && !granted; n++) begin @(negedge CLK); if (DRD_ADDR_READY) granted = 1; end
    @(posedge CLK); #1 DRD_ADDR_VALID = 0;
    for (int n = 0; n < 60 && drd_log.size() < d0 + 4; n++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    checks++; if (cmd_addr.size() != c0 + 2 || cmd_addr[c0 + 1] !== 30'h600 || cmd_wr[c0 + 1] !== 1'b0) begin
      failures++; $display("FAIL post_reset_cmd count=%0d want=2", cmd_addr.size() - c0);
    end
    checks++; if (wlog.size() != w0 + 1 || cmpl_cnt != k0) begin
      failures++; $display("FAIL aborted_write beats=%0d cmpl=%0d want 1/0", wlog.size() - w0, cmpl_cnt - k0);
    end
    checks++; if (drd_log.size() != d0 + 4) begin
      failures++; $display("FAIL post_reset_beats got=%0d want=4", drd_log.size() - d0);
    end else for (int j = 0; j < 4; j++) begin
      checks++; if (drd_log[d0 + j] !== pat(30'h600, j)) begin
        failures++; $display("FAIL post_reset_beat%0d got=%h want=%h", j, drd_log[d0 + j], pat(30'h600, j));
      end
    end
  endtask

  task automatic test_cmd_stall();
    int c0 = cmd_addr.size(), i0 = ins_log.size();
    bit granted = 0;
    cmd_rdy_en = 0;
    @(posedge CLK); #1 INS_ADDR = 30'h700; INS_ADDR_VALID = 1;
    for (int n = 0; n < 20 && !granted; n++) begin @(negedge CLK); if (INS_ADDR_READY) granted = 1; end
    @(posedge CLK); #1 INS_ADDR_VALID = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      checks++; if ({MEM_CMD_VALID, MEM_CMD_WRITE, MEM_CMD_ADDR} !== {2'b10, 30'h700}) begin
        failures++; $display("FAIL cmd_hold%0d got=%b/%b/%h want 1/0/0000700", n, MEM_CMD_VALID, MEM_CMD_WRITE, MEM_CMD_ADDR);
      end
    end
    cmd_rdy_en = 1;
    for (int n = 0; n < 60 && ins_log.size() < i0 + 4; n++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    checks++; if (cmd_addr.size() != c0 + 1 || ins_log.size() != i0 + 4) begin
      failures++; $display("FAIL cmd_stall cmds=%0d beats=%0d want 1/4", cmd_addr.size() - c0, ins_log.size() - i0);
    end
  endtask

  initial begin
    INS_ADDR = '0; DRD_ADDR = '0; DWR_ADDR = '0; DWR_DATA = '0; DWR_CONTROL = 0;
    INS_DATA_READY = 1; DRD_DATA_READY = 1; cmd_rdy_en = 1; wrdy_en = 1; spur = 0;
    test_reset();
    test_ins_read();
    test_round_robin();
    test_write_priority();
    test_rdata_stall();
    test_reset_mid_write();
    test_cmd_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 SHALL have parameter W, default 7: L2 bus width is 2^W bits (L2W = 128).
REQ-002 SHALL have parameter B, default 9: cache block is 2^B bits; BURST = 2^(B-W) beats (4).
REQ-003 SHALL have parameter AW, default 30: word-address width.
REQ-004 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-005 SHALL have port RSTN, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports INS_ADDR_VALID (in, 1), INS_ADDR_READY (out, 1) and INS_ADDR (in, AW): I-cache read request.
REQ-007 SHALL have ports INS_DATA_VALID (out, 1), INS_DATA_READY (in, 1) and INS_DATA (out, L2W): I-cache refill beats.
REQ-008 SHALL have ports DRD_ADDR_VALID (in, 1), DRD_ADDR_READY (out, 1), DRD_ADDR (in, AW), DRD_DATA_VALID (out, 1), DRD_DATA_READY (in, 1) and DRD_DATA (out, L2W): D-cache read.
REQ-009 SHALL have ports DWR_VALID (in, 1), DWR_READY (out, 1), DWR_ADDR (in, AW), DWR_DATA (in, L2W), DWR_CONTROL (in, 1) and DWR_COMPLETE (out, 1): D-cache write-back.
REQ-010 SHALL have ports MEM_CMD_VALID (out, 1), MEM_CMD_READY (in, 1), MEM_CMD_WRITE (out, 1), MEM_CMD_ADDR (out, AW) and MEM_CMD_CONTROL (out, 1): shared memory command.
REQ-011 SHALL have ports MEM_WDATA_VALID (out, 1), MEM_WDATA_READY (in, 1), MEM_WDATA (out, L2W), MEM_RDATA_VALID (in, 1), MEM_RDATA_READY (out, 1), MEM_RDATA (in, L2W) and MEM_WR_DONE (in, 1).

Function
REQ-012 SHALL use FSM states IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA, WR_WAIT; one transaction outstanding at a time.
REQ-013 In IDLE, SHALL grant with priority: pending write > reads; between INS and DRD reads, round-robin, pointer toggling to the other requester after each granted read.
REQ-014 On grant, SHALL latch requester ID, address and control in the same cycle the requester's READY pulses high (1 cycle), then enter RD_CMD/WR_CMD the next cycle.
REQ-015 In RD_CMD/WR_CMD, SHALL hold MEM_CMD_VALID=1 with stable address/WRITE/CONTROL until MEM_CMD_READY; then go to RD_DATA/WR_DATA.
REQ-016 In RD_DATA, SHALL route MEM_RDATA combinationally to the granted requester only; MEM_RDATA_READY = granted requester's DATA_READY; the other requester's DATA_VALID stays 0.
REQ-017 SHALL count accepted beats (valid & ready) with a log2(BURST)-bit counter; after beat BURST-1, SHALL return to IDLE next cycle.
REQ-018 In WR_DATA, beat 0 SHALL be the DWR_DATA latched at grant; beats 1..BURST-1 SHALL be taken via DWR_READY = MEM_WDATA_READY pass-through (DWR_DATA driven to MEM_WDATA).
REQ-019 In WR_WAIT, SHALL wait for MEM_WR_DONE, pulse DWR_COMPLETE for exactly 1 cycle, then return to IDLE.
REQ-020 Minimum turnaround SHALL be 1 IDLE cycle between transactions; no grant is issued outside IDLE.
REQ-021 Simultaneous INS, DRD and DWR requests in IDLE SHALL grant DWR; reads are then served in round-robin order.
REQ-022 Requests dropped before grant SHALL be ignored; VALID withdrawn after grant SHALL not abort the transaction.
REQ-023 MEM_RDATA_VALID outside RD_DATA SHALL be ignored, with MEM_RDATA_READY=0.

Reset
REQ-024 RSTN low SHALL asynchronously force IDLE, beat counter 0, round-robin pointer to INS, and all VALID, READY and DWR_COMPLETE outputs to 0, even mid-burst.
REQ-025 After RSTN rises, SHALL issue the first grant no earlier than the next rising CLK edge.

Structure
REQ-026 State encoding, requester-ID encoding and BURST derivation SHALL live in shared package l2_arb_pkg.
REQ-027 The round-robin selector SHALL be a sub-module rr_arb2 (2 requests, 1-bit pointer, update enable).

Verification
REQ-028 Single INS read at 0x0000054, memory delivers 4 beats with READY=1 -> 1 MEM_CMD (WRITE=0, ADDR=0x0000054) and 4 INS_DATA beats; DRD_DATA_VALID never set.
REQ-029 INS and DRD asserted together for 3 requests each -> grants alternate INS, DRD, INS, DRD, INS, DRD.
REQ-030 DWR, INS and DRD asserted in the same cycle -> DWR first, 4 MEM_WDATA beats, 1-cycle DWR_COMPLETE after MEM_WR_DONE, then INS.
REQ-031 INS_DATA_READY low for 2 cycles on beat 2 -> MEM_RDATA_READY low for the same cycles, beat count stays 4, no beat lost.
REQ-032 RSTN dropped during beat 1 of a write -> all outputs 0 immediately; next DRD request completes normally.
REQ-033 MEM_CMD_READY held low 10 cycles -> MEM_CMD_ADDR/WRITE stable, no second command issued.
